// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle between an upstream producer, the pipe_skid_reg stage and its consumer.
// The master modport is the environment side and the slave modport is the stage itself.
interface pipe_skid_reg_if #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output flush, in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
   );

   modport slave (
      input  flush, in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with an optional second (skid) entry, flush, and a saturating stall counter.
// All downstream-facing signals come from flops; in skid mode in_ready is decoded from state alone.
module pipe_skid_reg #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 16,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_skid_reg_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic              out_valid_r;
   logic              out_valid_s;
   logic [DATA_W-1:0] out_data_r;
   logic [DATA_W-1:0] out_data_s;
   logic [CTRL_W-1:0] out_ctrl_r;
   logic [CTRL_W-1:0] out_ctrl_s;
   logic [DATA_W-1:0] skid_data_r;
   logic [DATA_W-1:0] skid_data_s;
   logic [CTRL_W-1:0] skid_ctrl_r;
   logic [CTRL_W-1:0] skid_ctrl_s;
   logic [1:0]        occ_r;
   logic [1:0]        occ_s;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic              in_ready_s;
   logic              in_fire_s;
   logic              out_fire_s;

   // Upstream ready: state decode in skid mode, pass-through of out_ready in single-entry mode.
   always_comb begin
      if (SKID != 0) begin
         in_ready_s = (state_r != ST_SKID);
      end else begin
         in_ready_s = ~out_valid_r | bus.out_ready;
      end
   end

   assign in_fire_s  = bus.in_valid & in_ready_s;
   assign out_fire_s = out_valid_r & bus.out_ready;

   // Next-state and next-entry logic; flush wins over any handshake in the same cycle.
   always_comb begin
      state_s     = state_r;
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      out_ctrl_s  = out_ctrl_r;
      skid_data_s = skid_data_r;
      skid_ctrl_s = skid_ctrl_r;
      if (bus.flush) begin
         state_s     = ST_EMPTY;
         out_valid_s = 1'b0;
         out_ctrl_s  = {CTRL_W{1'b0}};
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_s     = ST_FULL;
                  out_valid_s = 1'b1;
                  out_data_s  = bus.in_data;
                  out_ctrl_s  = bus.in_ctrl;
               end else begin
                  state_s     = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (in_fire_s && (out_fire_s || (SKID == 0))) begin
                  out_data_s  = bus.in_data;
                  out_ctrl_s  = bus.in_ctrl;
               end else if (in_fire_s) begin
                  state_s     = ST_SKID;
                  skid_data_s = bus.in_data;
                  skid_ctrl_s = bus.in_ctrl;
               end else if (out_fire_s) begin
                  // The payload stays visible after departure; only the control is scrubbed.
                  state_s     = ST_EMPTY;
                  out_valid_s = 1'b0;
                  out_ctrl_s  = {CTRL_W{1'b0}};
               end else begin
                  state_s     = ST_FULL;
               end
            end
            ST_SKID: begin
               if (out_fire_s) begin
                  state_s     = ST_FULL;
                  out_data_s  = skid_data_r;
                  out_ctrl_s  = skid_ctrl_r;
               end else begin
                  state_s     = ST_SKID;
               end
            end
            default: begin
               state_s     = ST_EMPTY;
               out_valid_s = 1'b0;
               out_ctrl_s  = {CTRL_W{1'b0}};
            end
         endcase
      end
   end

   // Entry count that will be held after this edge.
   always_comb begin
      case (state_s)
         ST_EMPTY: occ_s = 2'd0;
         ST_FULL:  occ_s = 2'd1;
         ST_SKID:  occ_s = 2'd2;
         default:  occ_s = 2'd0;
      endcase
   end

   // State and entry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_ctrl_r  <= {CTRL_W{1'b0}};
         skid_data_r <= {DATA_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
         occ_r       <= 2'd0;
      end else begin
         state_r     <= state_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         out_ctrl_r  <= out_ctrl_s;
         skid_data_r <= skid_data_s;
         skid_ctrl_r <= skid_ctrl_s;
         occ_r       <= occ_s;
      end
   end

   // Saturating stall counter; deliberately unaffected by flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (out_valid_r && !bus.out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_ctrl  = out_ctrl_r;
   assign bus.occupancy = occ_r;
   assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench: a skid-mode stage (16-bit counter) and a single-entry stage (4-bit counter)
// share one random stimulus stream; each is checked against a queue-based reference model.
module tb_pipe_skid_reg;
   localparam int DW = 160;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          out_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;

   always #5 clk = ~clk;

   pipe_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) bus_a ();
   pipe_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4))  bus_b ();

   pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_skid (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) u_reg (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   assign bus_a.flush = flush;     assign bus_b.flush = flush;
   assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
   assign bus_a.in_data = in_data; assign bus_b.in_data = in_data;
   assign bus_a.in_ctrl = in_ctrl; assign bus_b.in_ctrl = in_ctrl;
   assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready;

   logic [1:0]    rdy;
   logic [1:0]    vld;
   logic [DW-1:0] odata [2];
   logic [CW-1:0] octrl [2];
   logic [1:0]    occ [2];
   logic [15:0]   stall [2];

   assign rdy[0] = bus_a.in_ready;   assign rdy[1] = bus_b.in_ready;
   assign vld[0] = bus_a.out_valid;  assign vld[1] = bus_b.out_valid;
   assign odata[0] = bus_a.out_data; assign odata[1] = bus_b.out_data;
   assign octrl[0] = bus_a.out_ctrl; assign octrl[1] = bus_b.out_ctrl;
   assign occ[0] = bus_a.occupancy;  assign occ[1] = bus_b.occupancy;
   assign stall[0] = bus_a.stall_cnt;
   assign stall[1] = {12'd0, bus_b.stall_cnt};

   entry_t        exp_q [2][$];
   int            checks = 0;
   int            failures = 0;

   task automatic chk(input string nm, input int d, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut=%0d actual=%h required=%h t=%0t", nm, d, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] v;
      v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return v;
   endfunction

   // Reference model: entries held = queue depth; capacity 2 (skid) or 1 (single register).
   int            held [2];
   int            exp_stall [2];
   logic [DW-1:0] last_d [2];

   initial begin
      entry_t head;
      logic   exp_rdy;
      int     smax;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               exp_q[d].delete();
               held[d] = 0;
               exp_stall[d] = 0;
               last_d[d] = '0;
            end else begin
               smax = (d == 0) ? 65535 : 15;
               exp_rdy = (d == 0) ? (held[d] < 2) : ((held[d] == 0) || out_ready);
               chk("in_ready", d, rdy[d], exp_rdy);
               chk("occupancy", d, occ[d], held[d]);
               chk("out_valid", d, vld[d], held[d] > 0);
               chk("stall_cnt", d, stall[d], exp_stall[d]);
               if (held[d] > 0) begin
                  if (exp_q[d].size() == 0) begin
                     failures++;
                     checks++;
                     $display("FAIL scoreboard_empty dut=%0d actual=0 required>=1", d);
                  end else begin
                     head = exp_q[d][0];
                     chk("out_data", d, odata[d], head.d);
                     chk("out_ctrl", d, octrl[d], head.c);
                     last_d[d] = head.d;
                     if (out_ready && !flush) void'(exp_q[d].pop_front());
                  end
                  if (!out_ready && exp_stall[d] != smax) exp_stall[d]++;
               end else begin
                  chk("out_data_hold", d, odata[d], last_d[d]);
                  chk("out_ctrl_zero", d, octrl[d], '0);
               end
               if (flush) begin
                  held[d] = 0;
                  exp_q[d].delete();
               end else begin
                  held[d] = held[d] - ((held[d] > 0 && out_ready) ? 1 : 0) + ((in_valid && exp_rdy) ? 1 : 0);
               end
            end
         end
      end
   end

   task automatic drive_cycle(input logic v, input logic r, input logic f, input logic [DW-1:0] dat);
      entry_t e;
      @(posedge clk);
      #1;
      in_valid  = v;
      out_ready = r;
      flush     = f;
      in_data   = dat;
      in_ctrl   = 16'($urandom_range(1, 65535));
      #2;
      e.d = in_data;
      e.c = in_ctrl;
      if (rst_n && !flush) begin
         for (int d = 0; d < 2; d++) begin
            if (in_valid && rdy[d]) exp_q[d].push_back(e);
         end
      end
   endtask

   task automatic check_reset_outputs();
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready", d, rdy[d], 1'b1);
         chk("rst_out_valid", d, vld[d], 1'b0);
         chk("rst_occupancy", d, occ[d], 2'd0);
         chk("rst_stall_cnt", d, stall[d], 16'd0);
         chk("rst_out_ctrl", d, octrl[d], '0);
         chk("rst_out_data", d, odata[d], '0);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_ctrl = '0;
      #2;
      check_reset_outputs();
      drive_cycle(1'b0, 1'b1, 1'b0, '0);
      drive_cycle(1'b0, 1'b1, 1'b0, '0);
      rst_n = 1'b1;

      // Streaming 1,2,3,...
      for (int i = 1; i <= 20; i++) drive_cycle(1'b1, 1'b1, 1'b0, DW'(i));

      // Backpressure into the skid entry, then a long stall to saturate the 4-bit counter.
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, rnd_data());
      for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, '0);

      // Flush while both entries are held and a new one is offered.
      drive_cycle(1'b1, 1'b0, 1'b0, rnd_data());
      drive_cycle(1'b1, 1'b0, 1'b0, rnd_data());
      drive_cycle(1'b1, 1'b1, 1'b1, rnd_data());
      drive_cycle(1'b0, 1'b1, 1'b0, '0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 31) == 0), rnd_data());
      end

      // Mid-stream asynchronous reset with two entries held.
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, rnd_data());
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      drive_cycle(1'b1, 1'b1, 1'b0, rnd_data());
      drive_cycle(1'b0, 1'b1, 1'b0, '0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 0, rdy[0], 1'b1);
      chk("post_rst_in_ready", 1, rdy[1], 1'b1);

      for (int i = 0; i < 60; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0, rnd_data());
      end
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 160, width of the payload carried between stages.
REQ-002 SHALL have parameter CTRL_W, default 16, width of the control bundle zeroed on bubbles.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single-entry register.
REQ-004 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous kill of all held entries (control hazard).
REQ-008 SHALL have port in_valid  input  1  upstream entry present.
REQ-009 SHALL have port in_ready  output  1  block accepts an entry this cycle.
REQ-010 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-011 SHALL have port in_ctrl  input  CTRL_W  upstream control bundle.
REQ-012 SHALL have port out_valid  output  1  downstream entry present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-014 SHALL have port out_data  output  DATA_W  payload of the head entry.
REQ-015 SHALL have port out_ctrl  output  CTRL_W  control of the head entry; all-zero when out_valid=0.
REQ-016 SHALL have port occupancy  output  2  entries held (0..2).
REQ-017 SHALL have port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-019 SHALL drive out_valid, out_data and out_ctrl directly from registers, with no combinational path from in_* to out_*.
REQ-020 SHALL, with SKID=1, implement states EMPTY (occ 0), FULL (occ 1, main entry), SKID (occ 2, main + skid entry).
REQ-021 SHALL, with SKID=1, drive in_ready = 1 in EMPTY and FULL and 0 in SKID, decoded from registered state only, independent of out_ready.
REQ-022 SHALL transition EMPTY->FULL on in_fire by loading main; otherwise remain EMPTY.
REQ-023 SHALL, in FULL: on in_fire & out_fire reload main and stay FULL; on in_fire only store in skid and go to SKID; on out_fire only go to EMPTY; otherwise hold.
REQ-024 SHALL, in SKID: on out_fire copy skid into main and go to FULL; otherwise hold both entries.
REQ-025 SHALL, with SKID=0, hold one entry and drive in_ready = ~out_valid | out_ready combinationally; occupancy SHALL never exceed 1.
REQ-026 SHALL deliver entries in acceptance order, with no loss or duplication, and 1-cycle latency from in_fire to out_valid when empty.
REQ-027 SHALL, on flush=1, clear all entries at the next edge (occupancy 0, state EMPTY, out_ctrl 0), overriding any simultaneous in_fire or out_fire.
REQ-028 SHALL discard an entry presented with in_fire in the same cycle as flush.
REQ-029 SHALL hold out_data at its last value when an entry leaves; only out_ctrl is forced to zero.
REQ-030 SHALL increment stall_cnt each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1; flush SHALL NOT clear it.
REQ-031 SHALL keep out_data, out_ctrl and skid contents stable while the entry is stalled.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force state EMPTY, out_valid 0, out_data 0, out_ctrl 0, skid contents 0, occupancy 0 and stall_cnt 0.
REQ-033 SHALL drive in_ready 1 during reset and after reset release.
REQ-034 SHALL discard all held entries when reset is asserted mid-operation; the first edge after release SHALL behave as in EMPTY.

Verification
REQ-035 SHALL pass streaming: SKID=1, in_valid=1 and out_ready=1 every cycle, in_data 1,2,3,... -> out_data 1,2,3,... one cycle later, occupancy stays 1, stall_cnt 0.
REQ-036 SHALL pass backpressure: FULL with A, out_ready=0, send B -> SKID, in_ready=0, stall_cnt +1 per cycle; out_ready=1 -> A out, then B out, no loss.
REQ-037 SHALL pass flush: SKID state with in_valid=1 and flush=1 -> next cycle out_valid 0, out_ctrl 0, occupancy 0, input dropped, stall_cnt unchanged.
REQ-038 SHALL pass mid-stream reset: occupancy 2, pull rst_n low mid-cycle -> outputs zero immediately, in_ready 1 after release.
REQ-039 SHALL pass SKID=0 mode: out_ready=0 with entry held -> in_ready 0 in the same cycle; out_ready=1 and in_valid=1 -> accept and replace in one cycle.
REQ-040 SHALL pass saturation: CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt stops at 15.
